rv32m_issue: RTL and testbench

Issue/writeback stage wrapped around the multi-cycle RV32M execution unit.
- Accepts a decoded instruction word plus register operands through a valid/ready handshake.
- Checks the word is an M-extension op, then launches the execution unit with held operands and `funct3`.
- Waits for the unit's completion, captures the result and error flag, and presents them with the destination register address to writeback through a second valid/ready handshake.
- Holds one operation in flight at a time.

---
 rtl/rv32m_issue_pkg.sv | 31 +++
 rtl/rv32m_issue.sv | 187 ++++++++++++++++++
 tb/tb_rv32m_issue.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32m_issue_pkg.sv
// rv32m_issue_pkg: shared constants for the RV32M issue/writeback stage.
//   - R-type opcode and the MULDIV funct7 that together identify an M op
//   - funct3 codes for the eight M-extension operations
//   - FSM state encoding used by rv32m_issue
//   - is_m_op(): decode helper for the M-op check
package rv32m_issue_pkg;

  localparam logic [6:0] OP_RTYPE      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_m_op(input logic [31:0] word);
    return (word[6:0] == OP_RTYPE) && (word[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/rv32m_issue.sv
// rv32m_issue: issue/writeback stage around a multi-cycle RV32M execution unit.
// Holds one operation in flight: accept -> launch -> wait -> writeback.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   inst_valid/ready    instruction-side handshake (ready only in IDLE)
//   inst, rs1_val/rs2_val  instruction word and operands
//   m_rs1/m_rs2/m_funct3   held operands and operation for the unit
//   m_in_valid          one-cycle launch pulse
//   m_rd/m_out_valid/m_in_error  unit result, valid and error flag
//   wb_valid/wb_ready   writeback handshake
//   wb_rd_addr/wb_data/wb_error/wb_timeout  writeback payload
//   illegal             one-cycle pulse when an accepted word is not an M op
//
// Build option: define RV32M_TIMEOUT_EN to force completion after TIMEOUT
// wait cycles (wb_timeout=1, zero data). Undefined: WAIT is unbounded and
// wb_timeout is tied low.
module rv32m_issue
  import rv32m_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] m_rs1,
  output logic [XLEN-1:0] m_rs2,
  output logic [2:0]      m_funct3,
  output logic            m_in_valid,
  input  logic [XLEN-1:0] m_rd,
  input  logic            m_out_valid,
  input  logic            m_in_error,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_error,
  output logic            wb_timeout,
  output logic            illegal
);

  localparam int CNT_MAX = (TIMEOUT > MIN_LAT) ? TIMEOUT : MIN_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAT_THR = cnt_t'((MIN_LAT > 0) ? MIN_LAT - 1 : 0);
  localparam cnt_t CNT_SAT = cnt_t'(CNT_MAX);
`ifdef RV32M_TIMEOUT_EN
  localparam cnt_t TO_LAST = cnt_t'(TIMEOUT - 1);
`endif

  // The counter saturates so an unbounded WAIT never wraps back below the
  // MIN_LAT threshold and starts masking a genuine completion.
  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == CNT_SAT) ? c : c + cnt_t'(1);
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  cnt_t            cnt_q, cnt_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_err_q, wb_err_d;
  logic            illegal_q, illegal_d;
`ifdef RV32M_TIMEOUT_EN
  logic            timeout_q, timeout_d;
`endif

  // Register-field bits of the word are not needed here; operands arrive
  // already read.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[24:15];

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rd_addr_d = rd_addr_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
    illegal_d = 1'b0;
`ifdef RV32M_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (inst_valid) begin
          funct3_d  = inst[14:12];
          rd_addr_d = inst[11:7];
          rs1_d     = rs1_val;
          rs2_d     = rs2_val;
          if (is_m_op(inst)) state_d = ST_ISSUE;
          else               illegal_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        // A valid seen before the window opens is left over from the
        // previous op and must not be captured.
        if (m_out_valid && (cnt_q >= LAT_THR)) begin
          wb_data_d = m_rd;
          wb_err_d  = m_in_error;
          state_d   = ST_DONE;
        end
`ifdef RV32M_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          wb_data_d = '0;
          wb_err_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
`ifdef RV32M_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      funct3_q  <= '0;
      rd_addr_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_err_q  <= 1'b0;
      illegal_q <= 1'b0;
`ifdef RV32M_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rd_addr_q <= rd_addr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
      illegal_q <= illegal_d;
`ifdef RV32M_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  // Ready is gated by reset so it reads low while reset is held.
  assign inst_ready = (state_q == ST_IDLE) && rst;
  assign m_in_valid = (state_q == ST_ISSUE);
  assign wb_valid   = (state_q == ST_DONE);
  assign m_rs1      = rs1_q;
  assign m_rs2      = rs2_q;
  assign m_funct3   = funct3_q;
  assign wb_rd_addr = rd_addr_q;
  assign wb_data    = wb_data_q;
  assign wb_error   = wb_err_q;
  assign illegal    = illegal_q;
`ifdef RV32M_TIMEOUT_EN
  assign wb_timeout = timeout_q;
`else
  assign wb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rv32m_issue.sv
// tb_rv32m_issue: directed bench for rv32m_issue with a behavioural RV32M
// execution unit alongside. The unit leaves its valid high after finishing
// and only drops it one cycle after the next launch, so every op after the
// first sees a stale valid at the start of WAIT.
module tb_rv32m_issue;

  localparam int XLEN    = 32;
  localparam int MIN_LAT = 2;
  localparam int TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            inst_valid = 1'b0;
  logic            inst_ready;
  logic [31:0]     inst = '0;
  logic [XLEN-1:0] rs1_val = '0, rs2_val = '0;
  logic [XLEN-1:0] m_rs1, m_rs2;
  logic [2:0]      m_funct3;
  logic            m_in_valid;
  logic [XLEN-1:0] m_rd;
  logic            m_out_valid;
  logic            m_in_error;
  logic            wb_valid;
  logic            wb_ready = 1'b1;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_data;
  logic            wb_error;
  logic            wb_timeout;
  logic            illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv32m_issue #(.XLEN(XLEN), .MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .m_rs1(m_rs1), .m_rs2(m_rs2), .m_funct3(m_funct3), .m_in_valid(m_in_valid),
    .m_rd(m_rd), .m_out_valid(m_out_valid), .m_in_error(m_in_error),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .wb_error(wb_error), .wb_timeout(wb_timeout),
    .illegal(illegal)
  );

  // Reference RV32M semantics; error flags divide-by-zero.
  function automatic logic [32:0] ref_op(input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic signed [31:0] a32, b32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    a32 = a;
    b32 = b;
    case (f3)
      3'b000: begin p = ua * ub; return {1'b0, p[31:0]}; end
      3'b001: begin p = sa * sb; return {1'b0, p[63:32]}; end
      3'b010: begin p = sa * $signed(ub); return {1'b0, p[63:32]}; end
      3'b011: begin p = ua * ub; return {1'b0, p[63:32]}; end
      3'b100: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, a};
        return {1'b0, 32'(a32 / b32)};
      end
      3'b101: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, a / b};
      end
      3'b110: begin
        if (b == 0) return {1'b1, a};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0};
        return {1'b0, 32'(a32 % b32)};
      end
      default: begin
        if (b == 0) return {1'b1, a};
        return {1'b0, a % b};
      end
    endcase
  endfunction

  // Behavioural execution unit.
  int          unit_lat = 0;
  logic        unit_mute = 1'b0;
  logic        u_ov, u_err, u_launch, u_busy;
  logic [31:0] u_rd;
  logic [32:0] u_res;
  int          u_cd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_ov <= 1'b0; u_err <= 1'b0; u_rd <= '0; u_launch <= 1'b0;
      u_busy <= 1'b0; u_cd <= 0; u_res <= '0;
    end else begin
      u_launch <= m_in_valid;
      if (m_in_valid) u_res <= ref_op(m_funct3, m_rs1, m_rs2);
      if (u_launch) begin
        if (unit_lat == 0) begin
          u_ov <= 1'b1; u_err <= u_res[32]; u_rd <= u_res[31:0];
        end else begin
          u_ov <= 1'b0; u_busy <= 1'b1; u_cd <= unit_lat;
        end
      end else if (u_busy) begin
        if (u_cd == 1) begin
          u_ov <= 1'b1; u_err <= u_res[32]; u_rd <= u_res[31:0]; u_busy <= 1'b0;
        end
        u_cd <= u_cd - 1;
      end
    end
  end

  assign m_out_valid = u_ov & ~unit_mute;
  assign m_rd        = u_rd;
  assign m_in_error  = u_err;

  // Event counters.
  int launch_cnt = 0, illegal_cnt = 0, wb_cnt = 0;
  always @(posedge clk) begin
    if (m_in_valid) launch_cnt <= launch_cnt + 1;
    if (illegal) illegal_cnt <= illegal_cnt + 1;
    if (wb_valid && wb_ready) wb_cnt <= wb_cnt + 1;
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic        err;
    logic        to;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int bp,
                       input logic [31:0] exp_data, input logic exp_err,
                       input logic exp_to, output int wait_cycles);
    int k, lc0;
    logic [31:0] d0;
    logic [4:0] r0;
    exp_t e;
    @(negedge clk);
    chk({tag, " ready"}, inst_ready, 1'b1);
    unit_lat = lat;
    wb_ready = (bp == 0);
    lc0 = launch_cnt;
    inst = ins; rs1_val = a; rs2_val = b; inst_valid = 1'b1;
    sb_q.push_back('{rd: ins[11:7], err: exp_err, to: exp_to, data: exp_data});
    @(negedge clk);
    inst_valid = 1'b0;
    chk({tag, " launch"}, {m_in_valid, inst_ready, m_funct3, m_rs1, m_rs2},
        {1'b1, 1'b0, ins[14:12], a, b});
    @(negedge clk);
    chk({tag, " launch once"}, m_in_valid, 1'b0);
    k = 0;
    while (!wb_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    wait_cycles = k;
    chk({tag, " wb_valid"}, {wb_valid, inst_ready}, {1'b1, 1'b0});
    chk({tag, " launches"}, launch_cnt - lc0, 1);
    if (bp > 0) begin
      d0 = exp_data;
      r0 = ins[11:7];
      repeat (bp) begin
        @(negedge clk);
        chk({tag, " hold"}, {wb_valid, inst_ready, wb_data, wb_rd_addr},
            {1'b1, 1'b0, d0, r0});
      end
      wb_ready = 1'b1;
    end
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " wb payload"}, {wb_rd_addr, wb_error, wb_timeout, wb_data},
          {e.rd, e.err, e.to, e.data});
    end
    @(negedge clk);
    chk({tag, " back to idle"}, {wb_valid, inst_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] tb_inst [5] = '{32'h02B51533, 32'h02B52533, 32'h02B53533,
                               32'h02B56533, 32'h02B50033};
  logic [31:0] tb_a    [5] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'hFFFFFFF9, 32'd9};
  logic [31:0] tb_b    [5] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd3, 32'd9};
  logic [31:0] tb_exp  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE,
                               32'hFFFFFFFF, 32'd81};

  initial begin
    int w, lc0, ic0, wc0;
    // Reset state.
    #12;
    chk("reset ready", inst_ready, 1'b0);
    chk("reset outs", {m_rs1, m_rs2, m_funct3, m_in_valid, wb_valid, wb_rd_addr,
                       wb_data, wb_error, wb_timeout, illegal}, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready after reset", inst_ready, 1'b1);

    // Main operations.
    do_op("MUL", 32'h02B50533, 32'd6, 32'd7, 1, 0, 32'd42, 1'b0, 1'b0, w);
    do_op("DIVU", 32'h02B55533, 32'd100, 32'd7, 3, 0, 32'd14, 1'b0, 1'b0, w);
    do_op("REMU", 32'h02B57533, 32'd100, 32'd7, 0, 0, 32'd2, 1'b0, 1'b0, w);
    do_op("DIV0", 32'h02B54533, 32'd5, 32'd0, 2, 0, 32'hFFFFFFFF, 1'b1, 1'b0, w);

    // Non-M op.
    lc0 = launch_cnt; ic0 = illegal_cnt; wc0 = wb_cnt;
    @(negedge clk);
    inst = 32'h00B50533; rs1_val = 32'd1; rs2_val = 32'd2; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    chk("illegal pulse", {illegal, inst_ready, m_in_valid}, {1'b1, 1'b1, 1'b0});
    @(negedge clk);
    chk("illegal one cycle", {illegal, inst_ready}, {1'b0, 1'b1});
    repeat (4) @(negedge clk);
    chk("illegal no launch/wb", {launch_cnt - lc0, wb_cnt - wc0, illegal_cnt - ic0},
        {32'd0, 32'd0, 32'd1});

    // Backpressure.
    do_op("MULH bp", 32'h02B51533, 32'hFFFFFFFD, 32'd7, 2, 5, 32'hFFFFFFFF, 1'b0, 1'b0, w);

    // Remaining ops, including rd = x0.
    for (int i = 0; i < 5; i++)
      do_op($sformatf("tbl%0d", i), tb_inst[i], tb_a[i], tb_b[i], i, 0,
            tb_exp[i], 1'b0, 1'b0, w);

    // Reset in WAIT discards the op.
    wc0 = wb_cnt;
    @(negedge clk);
    unit_lat = 20;
    inst = 32'h02B50533; rs1_val = 32'd11; rs2_val = 32'd13; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset in wait", {m_rs1, m_rs2, m_funct3, m_in_valid, wb_valid, wb_rd_addr,
                          wb_data, wb_error, wb_timeout, illegal, inst_ready}, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    chk("no wb after reset", {wb_cnt - wc0, wb_valid, inst_ready}, {32'd0, 1'b0, 1'b1});

    do_op("MUL after rst", 32'h02B50533, 32'd1000, 32'd1000, 1, 0, 32'd1000000,
          1'b0, 1'b0, w);

`ifdef RV32M_TIMEOUT_EN
    unit_mute = 1'b1;
    do_op("timeout", 32'h02B55533, 32'd50, 32'd5, 0, 0, 32'd0, 1'b0, 1'b1, w);
    chk("timeout cycles", w, TIMEOUT);
    unit_mute = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
